// File: rtl/dmem_resp.sv
// Data memory with an optional posted-write buffer, forwarding and drain FSM.
// Define DMEM_WBUF_EN to build the write buffer; otherwise writes go straight to the array.
module dmem_resp #(
    parameter int WORDS_LOG2 = 8,
    parameter int WB_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_wen_D,
    input  logic [31:0]               mem_addr_D,
    input  logic [31:0]               mem_wdata_D,
    output logic [31:0]               mem_rdata_D,
    input  logic                      flush,
    output logic [$clog2(WB_DEPTH):0] wb_count,
    output logic                      wb_empty
);
    localparam int WORDS = 1 << WORDS_LOG2;
    localparam int PW    = $clog2(WB_DEPTH);

    logic [WORDS_LOG2-1:0] idx;
    logic [31:0]           mem [WORDS];
    logic                  unused_addr;

    assign idx         = mem_addr_D[WORDS_LOG2+1:2];
    assign unused_addr = ^{mem_addr_D[31:WORDS_LOG2+2], mem_addr_D[1:0]};

`ifdef DMEM_WBUF_EN
    typedef enum logic [1:0] {IDLE, HOLD, DRAIN} state_t;

    state_t                state;
    logic [WORDS_LOG2-1:0] wb_idx  [WB_DEPTH];
    logic [31:0]           wb_data [WB_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         slot;
    logic [PW:0]           count;
    logic                  full;
    logic                  pop;
    logic                  hit;
    logic [31:0]           fwd;

    assign full = count == (PW+1)'(WB_DEPTH);
    assign pop  = state == DRAIN;

    // Reads never stall, so draining steals cycles without a CPU write
    always_comb begin
        state = IDLE;
        if (count != '0) begin
            if (!mem_wen_D || full || flush) state = DRAIN;
            else                             state = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (mem_wen_D) tail <= tail + 1'b1;
            if (pop)       head <= head + 1'b1;
            count <= count + (PW+1)'(mem_wen_D) - (PW+1)'(pop);
        end
    end

    // When full, tail == head: the popped head is read before it is overwritten
    always_ff @(posedge clk) begin
        if (!rst && mem_wen_D) begin
            wb_idx[tail]  <= idx;
            wb_data[tail] <= mem_wdata_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (pop) begin
            mem[wb_idx[head]] <= wb_data[head];
        end
    end

    // Walk oldest to youngest so the youngest match wins
    always_comb begin
        hit  = 1'b0;
        fwd  = '0;
        slot = head;
        for (int i = 0; i < WB_DEPTH; i++) begin
            slot = head + PW'(i);
            if ((PW+1)'(i) < count && wb_idx[slot] == idx) begin
                hit = 1'b1;
                fwd = wb_data[slot];
            end
        end
    end

    assign mem_rdata_D = hit ? fwd : mem[idx];
    assign wb_count    = count;
    assign wb_empty    = count == '0;
`else
    logic unused_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (mem_wen_D) begin
            mem[idx] <= mem_wdata_D;
        end
    end

    assign mem_rdata_D  = mem[idx];
    assign wb_count     = '0;
    assign wb_empty     = 1'b1;
    assign unused_flush = flush;
`endif
endmodule
